// File: rtl/seq_fft8_pkg.sv
// Shared types, constants, twiddle ROM, butterfly schedule and magnitude helper
// for the 8-point sequential FFT magnitude engine.
package seq_fft8_pkg;

  localparam int unsigned DW    = 13;
  localparam int unsigned FRAC  = DW - 1;
  localparam int unsigned NPT   = 8;
  localparam int unsigned NSLOT = 12;

  typedef logic signed [DW-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, FFT, MAG} state_e;

  // W^k = exp(-j*2*pi*k/8), k = 0..3, in Q1.FRAC
  localparam sample_t TW_RE [4] = '{sample_t'(4095), sample_t'(2896),
                                    sample_t'(0),    sample_t'(-2897)};
  localparam sample_t TW_IM [4] = '{sample_t'(0),     sample_t'(-2897),
                                    sample_t'(-4096), sample_t'(-2897)};

  // Butterfly schedule: slot = stage*4 + butterfly
  localparam logic [2:0] PAIR_A [NSLOT] = '{3'd0, 3'd2, 3'd4, 3'd6,
                                            3'd0, 3'd4, 3'd1, 3'd5,
                                            3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [2:0] PAIR_B [NSLOT] = '{3'd1, 3'd3, 3'd5, 3'd7,
                                            3'd2, 3'd6, 3'd3, 3'd7,
                                            3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [1:0] TW_SEL [NSLOT] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                            2'd0, 2'd0, 2'd2, 2'd2,
                                            2'd0, 2'd1, 2'd2, 2'd3};

  localparam logic [DW-1:0] MAG_MAX = DW'((1 << (DW - 1)) - 1);
  localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW - 1){1'b0}}};

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
    if (v == NEG_MIN) return MAG_MAX;
    if (v[DW-1])      return -v;
    return v;
  endfunction

  // Alpha-max-plus-beta-min estimate: max + min/4 + min/8
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic [DW-1:0] ar, ai, mx, mn;
    logic [DW:0]   sum;
    ar  = abs_sat(re);
    ai  = abs_sat(im);
    mx  = (ar > ai) ? ar : ai;
    mn  = (ar > ai) ? ai : ar;
    sum = {1'b0, mx} + {1'b0, mn >> 2} + {1'b0, mn >> 3};
    return (sum > {1'b0, MAG_MAX}) ? MAG_MAX : sum[DW-1:0];
  endfunction

endpackage

// File: rtl/seq_fft8_mag_if.sv
// Start/busy handshake plus sample and magnitude buses of the FFT engine.
interface seq_fft8_mag_if;
  import seq_fft8_pkg::*;

  logic                     start;
  logic                     busy;
  logic [NPT-1:0][DW-1:0]   x;
  logic [NPT-1:0][DW-1:0]   o;

  modport master (output start, output x, input busy, input o);
  modport slave  (input start, input x, output busy, output o);

endinterface

// File: rtl/fft8_bfly_unit.sv
// Registered radix-2 complex butterfly y1=(a+wb)/2, y2=(a-wb)/2 with saturation.
// FFT8_ROUND_EN selects round-half-up instead of truncation for the halving.
module fft8_bfly_unit
  import seq_fft8_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  cplx_t w_i,
  input  cplx_t a_i,
  input  cplx_t b_i,
  output cplx_t y1_o,
  output cplx_t y2_o
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 2 * DW + 2;
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = SW'(-(1 << (DW - 1)));
`ifdef FFT8_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1 << FRAC);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] wb_re, wb_im, a_re, a_im;
  cplx_t                y1_d, y2_d, y1_q, y2_q;

  // Drop FRAC bits of product alignment plus one for the /2, then clamp
  function automatic sample_t scale_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = (v + RND) >>> (FRAC + 1);
    if (s > S_MAX) return S_MAX[DW-1:0];
    if (s < S_MIN) return S_MIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  assign p_rr  = PW'(w_i.re) * PW'(b_i.re);
  assign p_ii  = PW'(w_i.im) * PW'(b_i.im);
  assign p_ri  = PW'(w_i.re) * PW'(b_i.im);
  assign p_ir  = PW'(w_i.im) * PW'(b_i.re);
  assign wb_re = SW'(p_rr) - SW'(p_ii);
  assign wb_im = SW'(p_ri) + SW'(p_ir);
  assign a_re  = SW'(a_i.re) <<< FRAC;
  assign a_im  = SW'(a_i.im) <<< FRAC;

  always_comb begin
    y1_d.re = scale_sat(a_re + wb_re);
    y1_d.im = scale_sat(a_im + wb_im);
    y2_d.re = scale_sat(a_re - wb_re);
    y2_d.im = scale_sat(a_im - wb_im);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

  assign y1_o = y1_q;
  assign y2_o = y2_q;

endmodule

// File: rtl/seq_fft8_mag.sv
// Sequential 8-point DIT FFT amplitude engine: load, 12 in-place butterfly
// slots on one shared unit, then an in-place magnitude pass in natural order.
module seq_fft8_mag
  import seq_fft8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  seq_fft8_mag_if.slave bus
);

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   busy_q;
  logic [NPT-1:0][DW-1:0] re_q, re_d, im_q, im_d;
  logic [3:0]             slot;
  logic [2:0]             ia, ib;
  logic [1:0]             tw;
  cplx_t                  w, a, b, y1, y2;

  // Each slot is two cycles: even cnt feeds the butterfly, odd cnt writes back
  assign slot = cnt_q[4:1];
  assign ia   = PAIR_A[slot];
  assign ib   = PAIR_B[slot];
  assign tw   = TW_SEL[slot];
  assign w    = {TW_RE[tw], TW_IM[tw]};
  assign a    = {re_q[ia], im_q[ia]};
  assign b    = {re_q[ib], im_q[ib]};

  fft8_bfly_unit u_bfly (
    .clk  (clk),
    .rst  (rst),
    .w_i  (w),
    .a_i  (a),
    .b_i  (b),
    .y1_o (y1),
    .y2_o (y2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      IDLE: ;
      FFT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q[0]) begin
          re_d[ia] = y1.re;
          im_d[ia] = y1.im;
          re_d[ib] = y2.re;
          im_d[ib] = y2.im;
        end
        if (cnt_q == 5'(2 * NSLOT - 1)) begin
          state_d = MAG;
          cnt_d   = '0;
        end
      end
      MAG: begin
        re_d[cnt_q[2:0]] = mag(re_q[cnt_q[2:0]], im_q[cnt_q[2:0]]);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(NPT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A start in any state restarts with a fresh bit-reversed load
    if (bus.start) begin
      state_d = FFT;
      cnt_d   = '0;
      for (int i = 0; i < int'(NPT); i++) begin
        re_d[i] = bus.x[bitrev3(3'(i))];
      end
      im_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_q != IDLE);
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.o    = re_q;

endmodule

// File: tb/tb_seq_fft8_mag.sv
// Self-checking bench for seq_fft8_mag: directed spectra plus randomized frames
// against a stage-by-stage integer FFT model and an ideal-value tolerance check.
module tb_seq_fft8_mag;
  import seq_fft8_pkg::*;

`ifdef FFT8_ROUND_EN
  localparam bit ROUND_BUILD = 1'b1;
`else
  localparam bit ROUND_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  seq_fft8_mag_if bus();

  seq_fft8_mag dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stim  [8];
  int ref_o [8];
  int alt_o [8];
  int tw_re [4] = '{4095, 2896, 0, -2897};
  int tw_im [4] = '{0, -2897, -4096, -2897};

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint sat_s(input longint v);
    if (v > 4095)  return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  function automatic longint halve(input longint v, input bit rnd);
    return rnd ? ((v + 4096) >>> 13) : (v >>> 13);
  endfunction

  function automatic int mag_ref(input longint r, input longint i);
    longint ar, ai, mx, mn, s;
    ar = (r < 0) ? -r : r;
    ai = (i < 0) ? -i : i;
    if (ar > 4095) ar = 4095;
    if (ai > 4095) ai = 4095;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    s  = mx + (mn >> 2) + (mn >> 3);
    if (s > 4095) s = 4095;
    return int'(s);
  endfunction

  // Textbook in-place DIT FFT over stim[], stage spans 1,2,4
  task automatic run_model(input bit rnd, output int res [8]);
    longint re [8];
    longint im [8];
    longint pr, pim, ar, ai;
    int half, ia, ib, t, rev;
    for (int n = 0; n < 8; n++) begin
      rev   = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      re[n] = stim[rev];
      im[n] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      for (int g = 0; g < 8; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          ia  = g + j;
          ib  = ia + half;
          t   = j * (4 >> s);
          pr  = longint'(tw_re[t]) * re[ib] - longint'(tw_im[t]) * im[ib];
          pim = longint'(tw_re[t]) * im[ib] + longint'(tw_im[t]) * re[ib];
          ar  = re[ia] * 4096;
          ai  = im[ia] * 4096;
          re[ia] = sat_s(halve(ar + pr, rnd));
          im[ia] = sat_s(halve(ai + pim, rnd));
          re[ib] = sat_s(halve(ar - pr, rnd));
          im[ib] = sat_s(halve(ai - pim, rnd));
        end
      end
    end
    for (int k = 0; k < 8; k++) res[k] = mag_ref(re[k], im[k]);
  endtask

  function automatic int out_val(input int k);
    return int'($signed(bus.o[k]));
  endfunction

  // Called #1 after an edge; returns #1 after the capturing edge
  task automatic start_run();
    for (int k = 0; k < 8; k++) bus.x[k] = DW'(stim[k]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) bus.x[k] = DW'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy) cyc++;
      else break;
    end
    check_val({tag, " busy cycles"}, cyc, 32, 0);
  endtask

  task automatic check_exact(input string tag);
    run_model(ROUND_BUILD, ref_o);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("%s o%0d", tag, k), out_val(k), ref_o[k], 0);
  endtask

  task automatic check_peak(input string tag, input int peak_bin, input int peak_val);
    for (int k = 0; k < 8; k++) begin
      if (k == peak_bin) check_val($sformatf("%s peak o%0d", tag, k), out_val(k), peak_val, 3);
      else               check_val($sformatf("%s leak o%0d", tag, k), out_val(k), 0, 2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    repeat (10) @(posedge clk);
    #1;
    check_val("reset busy", int'(bus.busy), 0, 0);
    for (int k = 0; k < 8; k++) check_val($sformatf("reset o%0d", k), out_val(k), 0, 0);

    // rst wins over a simultaneous start
    for (int k = 0; k < 8; k++) stim[k] = 1000 + k;
    for (int k = 0; k < 8; k++) bus.x[k] = DW'(stim[k]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst+start busy", int'(bus.busy), 0, 0);
    check_val("rst+start o0", out_val(0), 0, 0);

    for (int k = 0; k < 8; k++) stim[k] = 4095;
    start_run();
    wait_idle("dc");
    check_peak("dc", 0, 4095);
    check_exact("dc");

    for (int k = 0; k < 8; k++) stim[k] = (k % 2 == 0) ? -4096 : 4095;
    start_run();
    wait_idle("nyq");
    check_peak("nyq", 4, 4095);
    check_exact("nyq");

    stim = '{4095, 0, -1024, 0, 4095, 0, 1024, 0};
    start_run();
    wait_idle("mix");
    for (int k = 0; k < 8; k++)
      check_val($sformatf("mix o%0d", k), out_val(k), (k % 2 == 0) ? 1024 : 256, 3);
    check_exact("mix");

    for (int k = 0; k < 8; k++) stim[k] = -4096;
    start_run();
    wait_idle("negfs");
    check_exact("negfs");

    // Restart 10 cycles into a run; only the second frame may show up
    for (int k = 0; k < 8; k++) stim[k] = int'($urandom_range(0, 8191)) - 4096;
    start_run();
    repeat (9) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) stim[k] = int'($urandom_range(0, 8191)) - 4096;
    start_run();
    wait_idle("restart");
    check_exact("restart");

    stim = '{4095, 0, 0, 0, 0, 0, 0, 0};
    start_run();
    wait_idle("impulse");
    for (int k = 0; k < 8; k++)
      check_val($sformatf("impulse o%0d", k), out_val(k), 512, 2);
    check_exact("impulse");
    run_model(!ROUND_BUILD, alt_o);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("impulse alt-rounding o%0d", k), out_val(k), alt_o[k], 3);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) stim[k] = int'($urandom_range(0, 8191)) - 4096;
      start_run();
      wait_idle($sformatf("rand%0d", r));
      check_exact($sformatf("rand%0d", r));
    end

    // Outputs hold while idle even as x wiggles
    for (int k = 0; k < 8; k++) bus.x[k] = DW'($urandom);
    repeat (5) @(posedge clk);
    #1;
    check_val("hold busy", int'(bus.busy), 0, 0);
    check_exact("hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_fft8_mag.md
Name: seq_fft8_mag

Overview:
- 8-point radix-2 DIT FFT engine that computes the amplitude spectrum of 8 real samples.
- One shared, registered complex butterfly is time-multiplexed over 3 stages × 4 butterflies.
- A magnitude pass follows, and results come out in natural order.
- Sits between the audio sample framer and the spectrum display logic.

Parameters:
- DW, 13, sample/result width; signed fixed point Q1.(DW-1), full scale ±1.0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; samples x0..x7 are captured on this edge.
- busy  out  1  high while transforming; o0..o7 are valid when low.
- x0..x7  in  DW each  real time-domain samples, signed.
- o0..o7  out  DW each  magnitude |X[k]|/8, k = 0..7, non-negative.

Behaviour:
- Reset: state IDLE, busy=0, working buffer (re/im) cleared, so o0..o7=0. rst has priority over start.
- States: IDLE → FFT (on start) → MAG → IDLE.
- start is accepted in any state. A start while busy aborts the current run and reloads.
- Load on start edge: buf_re[i] = x[bitrev3(i)], i.e. order x0,x4,x2,x6,x1,x5,x3,x7. All buf_im = 0.
- FFT phase: 12 butterfly slots of 2 cycles each, 24 cycles total. Order is stage 0..2, butterfly 0..3.
  - Slot cycle A: the pair is read and the butterfly output is registered (1-cycle latency).
  - Slot cycle B: both results are written back in place.
- Pairs and twiddles:
  - Stage 0: (0,1) (2,3) (4,5) (6,7), all W0.
  - Stage 1: (0,2) (4,6) (1,3) (5,7), with W0 W0 W2 W2.
  - Stage 2: (0,4) (1,5) (2,6) (3,7), with W0 W1 W2 W3.
- Twiddles (Q1.12 for DW=13):
  - W0 = 4095 + j0.
  - W1 = 2896 − j2897.
  - W2 = 0 − j4096.
  - W3 = −2897 − j2897.
- Butterfly: y1 = (a + w·b)/2, y2 = (a − w·b)/2.
  - Products are full precision (2·DW bits). Sums use ≥2·DW+1 bits.
  - Each stage scales by 1/2 (total 1/8). Scaling uses arithmetic right shift (truncate toward −∞).
  - Results saturate to [−2^(DW−1), 2^(DW−1)−1].
- MAG phase: 8 cycles. Cycle k writes buf_re[k] = mag(buf_re[k], buf_im[k]).
  - mag = max(|re|,|im|) + (min>>2) + (min>>3).
  - |−2^(DW−1)| saturates to 2^(DW−1)−1, and the final sum saturates to 2^(DW−1)−1.
- Timing: start at edge 0; busy=1 from edge 1 through edge 32, and busy=0 from edge 33. Outputs are stable until the next start or rst.
- o[k] = buf_re[k] continuously. Values are intermediate (not meaningful) while busy=1.
- Inputs x0..x7 are sampled only on the start edge.

Optional Feature:
- Macro FFT8_ROUND_EN.
- Defined: the butterfly /2 adds half an LSB before the shift (round half up), then saturates.
- Undefined: plain truncation as above. Latency and all else are identical.

Decomposition:
- Package seq_fft8_pkg holds:
  - DW default and the FRAC = DW−1 constant;
  - the twiddle ROM constants (4 complex values);
  - the state enum {IDLE, FFT, MAG};
  - the stage pair/twiddle index tables;
  - the magnitude function.
- One sub-module, fft8_bfly_unit: registered complex butterfly (w, a, b → y1, y2) with 1-cycle latency, including scaling, saturation and rounding option.

Test Plan:
- rst held 10 cycles → busy=0, o0..o7 = 0. Then assert rst together with start → remains IDLE.
- All x = 4095, start pulse → busy high exactly 32 cycles. Expected o0 ≈ 4095 (±3 LSB), o1..o7 ≤ 2.
- x = [−4096, 4095, −4096, 4095, −4096, 4095, −4096, 4095] → o4 ≈ 4095 (±3 LSB), others ≤ 2.
- x = [4095, 0, −1024, 0, 4095, 0, 1024, 0] → expected o ≈ [1024, 256, 1024, 256, 1024, 256, 1024, 256], each ±3 LSB.
- Start re-pulsed 10 cycles into a run with new data → busy extends 32 cycles from the new start; outputs match the new data only.
- Single impulse x0 = 4095, rest 0 → all o ≈ 512 (±2). Check the with/without FFT8_ROUND_EN difference is ≤1 LSB per stage.
